// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Bundles the fetch-stage control inputs, the instruction-memory
//            port and the IF/ID pipeline outputs into one interface.
// Ports    : stall, flush, redirect_valid, redirect_pc   (control -> fetch)
//            imem_addr (fetch -> imem), imem_data (imem -> fetch)
//            ifid_instr, ifid_pc_plus4, ifid_valid, halted (fetch -> ID)
//            perf_cycles, perf_bubbles (only with FETCH_PERF_EN defined)
// Modports : slave  = the fetch stage itself
//            master = the surrounding core / environment
// Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_bubbles;
`endif

  modport slave (
    input  stall, flush, redirect_valid, redirect_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, halted
`ifdef FETCH_PERF_EN
    , output perf_cycles, perf_bubbles
`endif
  );

  modport master (
    output stall, flush, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, halted
`ifdef FETCH_PERF_EN
    , input perf_cycles, perf_bubbles
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : IF stage plus IF/ID pipeline register of the five-stage MIPS
//            core. Holds the PC, applies stall/flush/redirect, and on the
//            program-end word drains ID..WB before raising halted.
// Ports    : clk    - core clock, rising edge
//            reset  - synchronous, active-high
//            bus    - fetch_stage_if.slave (control, imem port, IF/ID outputs)
// Options  : FETCH_PERF_EN - adds perf_cycles / perf_bubbles counters
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [31:0]      instr, instr_nxt;
  logic [31:0]      pc4, pc4_nxt;
  logic             valid, valid_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bubble;

  logic [31:0] pc_plus4;
  logic [31:0] redir_target;
  logic        normal;
  logic        is_halt;

  assign pc_plus4     = pc + 32'd4;
  assign redir_target = {bus.redirect_pc[31:2], 2'b00};
  assign normal       = !bus.redirect_valid && !bus.flush && !bus.stall;
  assign is_halt      = (bus.imem_data == HALT_INSTR);

  // State and datapath register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      pc    <= RESET_PC;
      instr <= 32'd0;
      pc4   <= 32'd0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
      pc4   <= pc4_nxt;
      valid <= valid_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (normal && is_halt) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // A redirect here means the halt word was on a wrong path.
        if (bus.redirect_valid)              state_nxt = S_RUN;
        else if (!bus.stall && cnt == '0)    state_nxt = S_HALTED;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    pc_nxt    = pc;
    instr_nxt = instr;
    pc4_nxt   = pc4;
    valid_nxt = valid;
    cnt_nxt   = cnt;
    bubble    = 1'b0;
    case (state)
      S_RUN: begin
        if (bus.redirect_valid) begin
          pc_nxt = redir_target;
          bubble = 1'b1;
        end else if (bus.flush) begin
          bubble = 1'b1;
          if (!bus.stall) pc_nxt = pc_plus4;
        end else if (bus.stall) begin
          // hold PC and IF/ID
        end else if (is_halt) begin
          // The halt word itself is never passed to decode.
          bubble  = 1'b1;
          cnt_nxt = CNT_RELOAD;
        end else begin
          pc_nxt    = pc_plus4;
          instr_nxt = bus.imem_data;
          pc4_nxt   = pc_plus4;
          valid_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        bubble = 1'b1;
        if (bus.redirect_valid)            pc_nxt  = redir_target;
        else if (!bus.stall && cnt != '0)  cnt_nxt = cnt - 1'b1;
      end
      default: begin
        // HALTED: everything frozen until reset
      end
    endcase
    if (bubble) begin
      instr_nxt = 32'd0;
      valid_nxt = 1'b0;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.ifid_instr    = instr;
  assign bus.ifid_pc_plus4 = pc4;
  assign bus.ifid_valid    = valid;
  assign bus.halted        = (state == S_HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_cycles, perf_bubbles;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles  <= 32'd0;
      perf_bubbles <= 32'd0;
    end else if (state != S_HALTED) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (bubble) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end

  assign bus.perf_cycles  = perf_cycles;
  assign bus.perf_bubbles = perf_bubbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A behavioural model of the
//            fetch stage predicts IF/ID contents after each edge; predictions
//            are queued when stimulus is applied and compared after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] ADDI_W = 32'h2008_0001;
  localparam int          DRAIN  = 4;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .HALT_INSTR   (HALT_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] pcyc;
    logic [31:0] pbub;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cyc, m_bub;
  logic        m_valid;
  int          m_state, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc     = m_pc;
    e.instr  = m_instr;
    e.pc4    = m_pc4;
    e.valid  = m_valid;
    e.halted = (m_state == M_HALTED);
    e.pcyc   = m_cyc;
    e.pbub   = m_bub;
    return e;
  endfunction

  task automatic model_edge(input logic s, input logic f, input logic rv,
                            input logic [31:0] rpc, input logic [31:0] d);
    logic bub;
    int   st0;
    bub = 1'b0;
    st0 = m_state;
    if (m_state == M_RUN) begin
      if (rv) begin
        m_pc = rpc & 32'hFFFF_FFFC; bub = 1'b1;
      end else if (f) begin
        bub = 1'b1;
        if (!s) m_pc = m_pc + 32'd4;
      end else if (!s) begin
        if (d == HALT_W) begin
          bub = 1'b1; m_state = M_DRAIN; m_cnt = DRAIN - 1;
        end else begin
          m_instr = d; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end
    end else if (m_state == M_DRAIN) begin
      bub = 1'b1;
      if (rv) begin
        m_pc = rpc & 32'hFFFF_FFFC; m_state = M_RUN;
      end else if (!s) begin
        if (m_cnt == 0) m_state = M_HALTED;
        else m_cnt = m_cnt - 1;
      end
    end
    if (bub) begin
      m_instr = 32'd0; m_valid = 1'b0;
    end
    if (st0 != M_HALTED) begin
      m_cyc = m_cyc + 32'd1;
      if (bub) m_bub = m_bub + 32'd1;
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("pc",     bus.imem_addr,            e.pc);
    chk("instr",  bus.ifid_instr,           e.instr);
    chk("pc4",    bus.ifid_pc_plus4,        e.pc4);
    chk("valid",  {31'd0, bus.ifid_valid},  {31'd0, e.valid});
    chk("halted", {31'd0, bus.halted},      {31'd0, e.halted});
`ifdef FETCH_PERF_EN
    chk("perf_cycles",  bus.perf_cycles,  e.pcyc);
    chk("perf_bubbles", bus.perf_bubbles, e.pbub);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0; bus.imem_data = 32'd0;
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_state = M_RUN; m_cnt = 0; m_cyc = 32'd0; m_bub = 32'd0;
    exp_q.push_back(snap());
    @(posedge clk); #1;
    reset = 1'b0;
    compare_out();
  endtask

  task automatic cyc(input logic s, input logic f, input logic rv,
                     input logic [31:0] rpc, input logic [31:0] d);
    @(negedge clk);
    bus.stall = s; bus.flush = f; bus.redirect_valid = rv;
    bus.redirect_pc = rpc; bus.imem_data = d;
    model_edge(s, f, rv, rpc, d);
    exp_q.push_back(snap());
    @(posedge clk); #1;
    compare_out();
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0; bus.imem_data = 32'd0;

    // reset state
    do_reset();
    chk("rst_pc",     bus.imem_addr, 32'h0);
    chk("rst_instr",  bus.ifid_instr, 32'h0);
    chk("rst_valid",  {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);

    // sequential fetch, then a two-cycle stall at pc=8
    cyc(0, 0, 0, 0, ADDI_W);
    cyc(0, 0, 0, 0, ADDI_W);
    chk("seq_pc8", bus.imem_addr, 32'h8);
    cyc(1, 0, 0, 0, ADDI_W);
    cyc(1, 0, 0, 0, ADDI_W);
    chk("stall_pc",  bus.imem_addr, 32'h8);
    chk("stall_pc4", bus.ifid_pc_plus4, 32'h8);
    cyc(0, 0, 0, 0, ADDI_W);
    chk("resume_pc",  bus.imem_addr, 32'hC);
    chk("resume_pc4", bus.ifid_pc_plus4, 32'hC);
    chk("resume_ins", bus.ifid_instr, ADDI_W);

    // halt word at 0x10, drain to halted, redirect ignored afterwards
    cyc(0, 0, 0, 0, 32'h0000_0020);
    cyc(0, 0, 0, 0, HALT_W);
    for (int i = 0; i < DRAIN - 1; i++) cyc(0, 0, 0, 0, ADDI_W);
    chk("not_yet_halted", {31'd0, bus.halted}, 32'd0);
    cyc(0, 0, 0, 0, ADDI_W);
    chk("halted_up", {31'd0, bus.halted}, 32'd1);
    chk("halt_pc",   bus.imem_addr, 32'h10);
    cyc(1, 1, 1, 32'h200, ADDI_W);
    chk("halted_frozen_pc", bus.imem_addr, 32'h10);

    // speculative halt cancelled by redirect during drain
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, ADDI_W);
    cyc(0, 0, 0, 0, HALT_W);
    cyc(0, 0, 0, 0, ADDI_W);
    cyc(0, 0, 1, 32'h80, ADDI_W);
    chk("cancel_pc", bus.imem_addr, 32'h80);
    cyc(0, 0, 0, 0, ADDI_W);
    chk("cancel_run", {31'd0, bus.halted}, 32'd0);

    // redirect beats stall and clears low address bits
    cyc(1, 0, 1, 32'h43, ADDI_W);
    chk("redir_pc",    bus.imem_addr, 32'h40);
    chk("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("redir_instr", bus.ifid_instr, 32'd0);

    // flush without and with stall
    cyc(0, 0, 0, 0, ADDI_W);
    cyc(0, 1, 0, 0, ADDI_W);
    chk("flush_pc", bus.imem_addr, 32'h48);
    cyc(1, 1, 0, 0, ADDI_W);
    chk("flush_stall_pc", bus.imem_addr, 32'h48);

    // stalls during drain hold the countdown
    cyc(0, 0, 0, 0, HALT_W);
    cyc(1, 0, 0, 0, ADDI_W);
    cyc(1, 0, 0, 0, ADDI_W);
    for (int i = 0; i < DRAIN; i++) cyc(0, 0, 0, 0, ADDI_W);
    do_reset();

    // PC wrap at top of address space
    cyc(0, 0, 1, 32'hFFFF_FFFC, ADDI_W);
    cyc(0, 0, 0, 0, ADDI_W);
    chk("wrap_pc",  bus.imem_addr, 32'h0);
    chk("wrap_pc4", bus.ifid_pc_plus4, 32'h0);

`ifdef FETCH_PERF_EN
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, ADDI_W);
    cyc(0, 1, 0, 0, ADDI_W);
    cyc(0, 0, 1, 32'h100, ADDI_W);
    chk("perf10_cycles",  bus.perf_cycles, 32'd10);
    chk("perf10_bubbles", bus.perf_bubbles, 32'd2);
`endif

    // randomised traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        s, f, rv;
      logic [31:0] rpc, d;
      if (m_state == M_HALTED && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        s   = ($urandom_range(0, 3) == 0);
        f   = ($urandom_range(0, 9) == 0);
        rv  = ($urandom_range(0, 9) == 0);
        rpc = $urandom;
        d   = ($urandom_range(0, 11) == 0) ? HALT_W : $urandom;
        cyc(s, f, rv, rpc, d);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
